// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin front end for one shared bitwise logic unit.
// Requesters compete through valid/ready; the winning operation is evaluated
// and parked in a single registered response slot until the consumer takes it.
module logic_unit_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 1,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_op_err
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_ILL  = 3'd7
  } opcode_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  slot_state_e      state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic             found;
  logic [IDW-1:0]   winIdx;
  logic [IDW-1:0]   cand;
  logic             canAccept;
  logic             accept;
  logic [2:0]       winOp;
  logic [WIDTH-1:0] winA, winB;
  logic [WIDTH-1:0] aluResult;
  logic             aluErr;

  // Index arithmetic modulo NUM_REQ, which need not be a power of two.
  function automatic logic [IDW-1:0] wrapAdd(input logic [IDW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[IDW-1:0];
  endfunction

  // The slot can take a new result when empty or when it is being drained now.
  assign canAccept = (state_q == EMPTY) | rsp_ready;

  // Round-robin search: first valid requester at or after the pointer wins.
  always_comb begin
    found  = 1'b0;
    winIdx = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrapAdd(ptr_q, k);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winIdx = cand;
      end
    end
  end

  // Grant only the winner, only when the slot has room and reset is released.
  always_comb begin
    req_ready = '0;
    if (rst_n && found && canAccept) req_ready[winIdx] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  // Only the winner's slices are selected, so other requesters' operands never leak.
  assign winOp = req_op[3*winIdx +: 3];
  assign winA  = req_a[WIDTH*winIdx +: WIDTH];
  assign winB  = req_b[WIDTH*winIdx +: WIDTH];

  // The shared bitwise logic unit; opcode 7 yields zero and flags an error.
  always_comb begin
    aluResult = '0;
    aluErr    = 1'b0;
    case (opcode_e'(winOp))
      OP_AND:  aluResult = winA & winB;
      OP_OR:   aluResult = winA | winB;
      OP_NAND: aluResult = ~(winA & winB);
      OP_NOR:  aluResult = ~(winA | winB);
      OP_XOR:  aluResult = winA ^ winB;
      OP_XNOR: aluResult = ~(winA ^ winB);
      OP_NOTA: aluResult = ~winA;
      OP_ILL:  aluErr    = 1'b1;
      default: aluErr    = 1'b1;
    endcase
  end

  // Slot next state: load on accept (push wins over pop), empty on a bare pop.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    result_d = result_q;
    err_d    = err_q;
    if (accept) begin
      state_d  = FULL;
      id_d     = winIdx;
      result_d = aluResult;
      err_d    = aluErr;
      ptr_d    = wrapAdd(winIdx, 1);
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d  = EMPTY;
    end
  end

  // Slot and pointer registers; reset drops any held response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      ptr_q    <= '0;
      id_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_op_err = err_q;

endmodule
